// File: rtl/stack_pkg.sv
// Shared constants and op encoding for the operand stack.
// The optional sticky error flags are enabled with the STACK_ERR_FLAGS_EN macro.
package stack_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int PTR_W     = $clog2(DEPTH_DEF + 1);

  // Encoding is {push, pop}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage for the operand stack: one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module stack_regfile
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO operand stack for the stack CPU: push/pop/replace/peek with saturating sp.
// Define STACK_ERR_FLAGS_EN to get sticky overflow/underflow flags; otherwise they read 0.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       tos,
  input  logic [WIDTH-1:0]           dataIn,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  logic [SPW-1:0]   sp;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] top_data;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    waddr;
  logic             we;
  logic             peek;
  op_e              op;

  assign op       = decode_op(push, pop);
  assign full     = (sp == SPW'(DEPTH));
  assign empty    = (sp == '0);
  assign count    = sp;
  // sp-1 wraps to the last slot when empty; the read is masked by empty below
  assign top_addr = AW'(sp - SPW'(1));

  // Replace overwrites the top slot; a plain push (or replace on empty) lands at sp
  always_comb begin
    we    = 1'b0;
    waddr = sp[AW-1:0];
    if (rst_n) begin
      unique case (op)
        OP_PUSH: we = !full;
        OP_REPL: begin
          we = 1'b1;
          if (!empty) waddr = top_addr;
        end
        default: we = 1'b0;
      endcase
    end
  end

  stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (dataIn),
    .raddr (top_addr),
    .rdata (rdata)
  );

  assign peek     = pop | tos;
  assign top_data = empty ? '0 : rdata;
  assign dataOut  = peek ? top_data : dout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp     <= '0;
      dout_q <= '0;
    end else begin
      if (peek) dout_q <= top_data;
      unique case (op)
        OP_PUSH: if (!full)  sp <= sp + SPW'(1);
        OP_POP:  if (!empty) sp <= sp - SPW'(1);
        OP_REPL: if (empty)  sp <= SPW'(1);
        default: ;
      endcase
    end
  end

`ifdef STACK_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (op == OP_PUSH && full) ovf_q <= 1'b1;
      if ((op == OP_POP || op == OP_REPL) && empty) udf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit (WIDTH=8, DEPTH=16); flag expectations follow STACK_ERR_FLAGS_EN.
module tb_stack_unit;

`ifdef STACK_ERR_FLAGS_EN
  localparam logic FLAG = 1'b1;
`else
  localparam logic FLAG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0, pop = 1'b0, tos = 1'b0;
  logic [7:0] dataIn = '0;
  logic [7:0] dataOut;
  logic       full, empty, overflow, underflow;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  stack_unit #(.WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .tos       (tos),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; tos = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    push = 1'b1; pop = 1'b0; tos = 1'b0; dataIn = d;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
    checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dataOut); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_push();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    tos = 1'b1;
    #1;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL push_count got=%0d exp=3", count); end
    checks++; if (dataOut !== 8'h33) begin errors++; $display("FAIL push_tos got=%h exp=33", dataOut); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL push_empty got=%b exp=0", empty); end
    idle();
  endtask

  task automatic test_pop();
    logic [7:0] exp [3];
    exp[0] = 8'h33; exp[1] = 8'h22; exp[2] = 8'h11;
    pop = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dataOut !== exp[i]) begin errors++; $display("FAIL pop_data%0d got=%h exp=%h", i, dataOut, exp[i]); end
      cycle();
    end
    idle();
    #1;
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL pop_drained got=%b/%0d exp=1/0", empty, count); end
    checks++; if (dataOut !== 8'h11) begin errors++; $display("FAIL pop_hold got=%h exp=11", dataOut); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) push_word(8'(i));
    checks++; if (full !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL full_fill got=%b/%0d exp=1/16", full, count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_noovf got=%b exp=0", overflow); end
    push_word(8'hAA);
    tos = 1'b1;
    #1;
    checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL ovf_count got=%0d/%b exp=16/1", count, full); end
    checks++; if (dataOut !== 8'h0F) begin errors++; $display("FAIL ovf_top got=%h exp=0f", dataOut); end
    checks++; if (overflow !== FLAG) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", overflow, FLAG); end
    // replace on a full stack is not an overflow
    idle();
    do_reset();
    for (int i = 0; i < 16; i++) push_word(8'(i));
    push = 1'b1; pop = 1'b1; dataIn = 8'hEE;
    cycle();
    idle();
    tos = 1'b1;
    #1;
    checks++; if (count !== 5'd16 || dataOut !== 8'hEE) begin errors++; $display("FAIL repl_full got=%0d/%h exp=16/ee", count, dataOut); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL repl_full_ovf got=%b exp=0", overflow); end
    idle();
    push_word(8'hAA);
  endtask

  task automatic test_reset_push();
    pop = 1'b1;
    for (int i = 0; i < 11; i++) cycle();
    idle();
    #1;
    checks++; if (count !== 5'd5 || overflow !== FLAG) begin errors++; $display("FAIL prerst got=%0d/%b exp=5/%b", count, overflow, FLAG); end
    rst_n = 1'b0; push = 1'b1; dataIn = 8'h44;
    cycle();
    rst_n = 1'b1; idle();
    #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL rstpush_count got=%0d/%b exp=0/1", count, empty); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rstpush_flags got=%b%b exp=00", overflow, underflow); end
    checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL rstpush_dout got=%h exp=00", dataOut); end
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    #1;
    checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL udf_dout got=%h exp=00", dataOut); end
    cycle();
    idle();
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL udf_count got=%0d exp=0", count); end
    checks++; if (underflow !== FLAG) begin errors++; $display("FAIL udf_flag got=%b exp=%b", underflow, FLAG); end
    push = 1'b1; pop = 1'b1; dataIn = 8'h5C;
    cycle();
    idle();
    tos = 1'b1;
    #1;
    checks++; if (count !== 5'd1 || dataOut !== 8'h5C) begin errors++; $display("FAIL repl_empty got=%0d/%h exp=1/5c", count, dataOut); end
    checks++; if (underflow !== FLAG) begin errors++; $display("FAIL udf_sticky got=%b exp=%b", underflow, FLAG); end
    idle();
  endtask

  task automatic test_tos_push();
    push = 1'b1; tos = 1'b1; dataIn = 8'h66;
    #1;
    checks++; if (dataOut !== 8'h5C) begin errors++; $display("FAIL tospush_pre got=%h exp=5c", dataOut); end
    cycle();
    idle();
    #1;
    checks++; if (dataOut !== 8'h5C) begin errors++; $display("FAIL tospush_hold got=%h exp=5c", dataOut); end
    tos = 1'b1;
    #1;
    checks++; if (dataOut !== 8'h66 || count !== 5'd2) begin errors++; $display("FAIL tospush_post got=%h/%0d exp=66/2", dataOut, count); end
    idle();
  endtask

  task automatic test_replace();
    do_reset();
    push_word(8'h01);
    push_word(8'h02);
    push = 1'b1; pop = 1'b1; dataIn = 8'h7E;
    cycle();
    idle();
    #1;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL repl_count got=%0d exp=2", count); end
    pop = 1'b1;
    #1;
    checks++; if (dataOut !== 8'h7E) begin errors++; $display("FAIL repl_pop0 got=%h exp=7e", dataOut); end
    cycle();
    checks++; if (dataOut !== 8'h01) begin errors++; $display("FAIL repl_pop1 got=%h exp=01", dataOut); end
    cycle();
    idle();
    #1;
    checks++; if (count !== 5'd0 || underflow !== 1'b0) begin errors++; $display("FAIL repl_end got=%0d/%b exp=0/0", count, underflow); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_full();
    test_reset_push();
    test_underflow();
    test_tos_push();
    test_replace();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
